// File: rtl/sdram_pkg.sv
// Shared types and constants for the bus-to-SDRAM-host-port bridge.
package sdram_pkg;

    localparam int unsigned BUS_DATA_WIDTH = 32;
    localparam int unsigned H_ADDR_WIDTH   = 31;
    localparam int unsigned H_DATA_WIDTH   = 16;

    // Halfword select appended as the LSB of the controller address
    localparam logic HALF_LO = 1'b0;
    localparam logic HALF_HI = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        ACK  = 2'd3
    } bridge_state_t;

    // Expand halfword byte enables into a bit mask so disabled bytes read as zero
    function automatic logic [H_DATA_WIDTH-1:0] half_mask(input logic [1:0] be);
        return {{8{be[1]}}, {8{be[0]}}};
    endfunction

endpackage

// File: rtl/sdram_bus_bridge.sv
// Adapts 32-bit bus accesses to the 16-bit sdram_controller host port,
// issuing low then high halfword transactions and merging read data.
module sdram_bus_bridge
    import sdram_pkg::*;
#(
    parameter int unsigned BUS_ADDR_WIDTH = 30,
    parameter bit          ZERO_BE_ACK    = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      bus_access,
    input  logic [BUS_ADDR_WIDTH-1:0] bus_addr,
    input  logic                      bus_wr_en,
    input  logic [3:0]                bus_bytesel,
    input  logic [BUS_DATA_WIDTH-1:0] bus_wr_val,
    output logic [BUS_DATA_WIDTH-1:0] bus_data,
    output logic                      bus_ack,
    output logic [H_ADDR_WIDTH-1:0]   h_addr,
    output logic [H_DATA_WIDTH-1:0]   h_wdata,
    output logic                      h_wr_en,
    output logic [1:0]                h_bytesel,
    input  logic [H_DATA_WIDTH-1:0]   h_rdata,
    input  logic                      h_compl,
    input  logic                      h_config_done
);

    bridge_state_t state, state_d;

    logic [BUS_ADDR_WIDTH-1:0] addr_q, addr_n;
    logic                      wr_en_q, wr_en_n;
    logic [3:0]                be_q, be_n;
    logic [BUS_DATA_WIDTH-1:0] wval_q, wval_n;
    logic [BUS_DATA_WIDTH-1:0] rdata_q;
    logic                      latch, cap_lo, cap_hi;

    // Next-state logic; the request fields seen by the output registers come
    // straight from the bus in the latch cycle so the first half starts at once
    always_comb begin
        state_d = state;
        latch   = 1'b0;
        cap_lo  = 1'b0;
        cap_hi  = 1'b0;
        case (state)
            IDLE: begin
                // !bus_ack keeps the still-held request from retriggering
                if (bus_access && h_config_done && !bus_ack) begin
                    if (|bus_bytesel[1:0]) begin
                        latch   = 1'b1;
                        state_d = LOW;
                    end else if (|bus_bytesel[3:2]) begin
                        latch   = 1'b1;
                        state_d = HIGH;
                    end else if (ZERO_BE_ACK) begin
                        latch   = 1'b1;
                        state_d = ACK;
                    end
                end
            end
            LOW: begin
                if (h_compl) begin
                    cap_lo  = 1'b1;
                    state_d = (|be_q[3:2]) ? HIGH : ACK;
                end
            end
            HIGH: begin
                if (h_compl) begin
                    cap_hi  = 1'b1;
                    state_d = ACK;
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        addr_n  = latch ? bus_addr    : addr_q;
        wr_en_n = latch ? bus_wr_en   : wr_en_q;
        be_n    = latch ? bus_bytesel : be_q;
        wval_n  = latch ? bus_wr_val  : wval_q;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    // Request capture and read-data merge; rdata starts cleared for each access
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            wr_en_q <= 1'b0;
            be_q    <= '0;
            wval_q  <= '0;
            rdata_q <= '0;
        end else begin
            addr_q  <= addr_n;
            wr_en_q <= wr_en_n;
            be_q    <= be_n;
            wval_q  <= wval_n;
            if (latch)
                rdata_q <= '0;
            else if (cap_lo)
                rdata_q[15:0] <= h_rdata & half_mask(be_q[1:0]);
            else if (cap_hi)
                rdata_q[31:16] <= h_rdata & half_mask(be_q[3:2]);
        end
    end

    // Registered outputs, loaded with the values of the state being entered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_data  <= '0;
            bus_ack   <= 1'b0;
            h_addr    <= '0;
            h_wdata   <= '0;
            h_wr_en   <= 1'b0;
            h_bytesel <= '0;
        end else begin
            bus_ack <= (state == ACK);
            if (state == ACK) bus_data <= rdata_q;
            case (state_d)
                LOW: begin
                    h_addr    <= H_ADDR_WIDTH'({addr_n, HALF_LO});
                    h_bytesel <= be_n[1:0];
                    h_wdata   <= wval_n[15:0];
                    h_wr_en   <= wr_en_n;
                end
                HIGH: begin
                    h_addr    <= H_ADDR_WIDTH'({addr_n, HALF_HI});
                    h_bytesel <= be_n[3:2];
                    h_wdata   <= wval_n[31:16];
                    h_wr_en   <= wr_en_n;
                end
                default: begin
                    h_bytesel <= 2'b00;
                    h_wr_en   <= 1'b0;
                end
            endcase
        end
    end

endmodule
